mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter RAM_AW, default 17, meaning the RAM byte-address width.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-low (0 = reset, sampled on the rising edge of clk).
REQ-004 SHALL have port if_req  input  1  instruction-fetch request; held with if_addr until if_done.
REQ-005 SHALL have port if_addr  input  32  fetch byte address.
REQ-006 SHALL have port if_done  output  1  one-cycle pulse; if_data is valid in the same cycle.
REQ-007 SHALL have port if_data  output  32  fetched instruction word, little-endian.
REQ-008 SHALL have port mem_req  input  1  load/store request; held with mem_we, mem_addr, mem_len and mem_wdata until mem_done.
REQ-009 SHALL have port mem_we  input  1  1 = store, 0 = load.
REQ-010 SHALL have port mem_addr  input  32  load/store byte address.
REQ-011 SHALL have port mem_len  input  3  byte count: 1, 2 or 4.
REQ-012 SHALL have port mem_wdata  input  32  store data; the low mem_len bytes are written.
REQ-013 SHALL have port mem_done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port mem_rdata  output  32  load data, zero-extended, valid when mem_done is high.
REQ-015 SHALL have port ram_din  input  8  RAM read byte; valid one cycle after its address.
REQ-016 SHALL have port ram_dout  output  8  RAM write byte.
REQ-017 SHALL have port ram_a  output  RAM_AW  RAM byte address, taken from the low RAM_AW bits of the request address.
REQ-018 SHALL have port ram_wr  output  1  1 = write ram_dout to ram_a this cycle.

Function
REQ-019 SHALL implement four states: IDLE, READ, WRITE and DONE.
REQ-020 SHALL, in IDLE, grant mem_req before if_req when both are high; an accepted transfer SHALL never be aborted except by reset.
REQ-021 SHALL latch the granted requester's address, length (4 for fetch), write data and identity on acceptance.
REQ-022 SHALL sequence a READ of N bytes as follows: the address of byte k (k = 0..N-1) is driven in cycle k+1 after acceptance; ram_din is captured in cycle k+2; state DONE is entered in cycle N+2.
REQ-023 SHALL sequence a WRITE of N bytes with ram_wr=1, ram_a=addr+k and ram_dout=wdata[8k+7:8k] in cycle k+1, entering DONE in cycle N+1.
REQ-024 SHALL assemble read data little-endian: byte k maps to bits [8k+7:8k], and bits above 8N are 0.
REQ-025 SHALL, in DONE, pulse exactly one of if_done or mem_done for one cycle and then return to IDLE.
REQ-026 SHALL hold if_data and mem_rdata stable after a done pulse until the next completion for the same requester.
REQ-027 SHALL treat mem_len values other than 1 and 2 as 4.
REQ-028 SHALL compute addresses modulo 2^RAM_AW (wrap-around at the top of RAM).
REQ-029 SHALL drive ram_wr=0, ram_a=0 and ram_dout=0 in every cycle in which no byte is issued.
REQ-030 SHALL ignore any requests that arrive during READ, WRITE or DONE; they are evaluated in the next IDLE.

Reset
REQ-031 SHALL, while rst=0 at a clock edge, enter IDLE and clear all outputs and internal registers to 0.
REQ-032 SHALL abort any in-flight transfer on reset, with no done pulse and no further RAM writes.

Configuration
REQ-033 SHALL add, when MEM_CTRL_PERF_CNT_EN is defined, outputs perf_if_cnt[31:0] and perf_mem_cnt[31:0]; each increments on its done pulse, wraps at 2^32 and is cleared by reset.
REQ-034 SHALL, when MEM_CTRL_PERF_CNT_EN is undefined, omit the perf_if_cnt and perf_mem_cnt ports and their counters, leaving behaviour otherwise identical.

Verification
REQ-035 Fetch: if_req with if_addr=0x100 and RAM[0x100..0x103]=13,05,00,00 -> if_done in cycle 6, if_data=0x00000513.
REQ-036 Conflict: if_req and mem_req rise together (load, len 4) -> mem_done first, in cycle 6; the fetch is then accepted in the following IDLE and if_done arrives 6 cycles later.
REQ-037 Store: mem_we=1, len=2, addr=0x20, wdata=0xAABBCCDD -> ram_wr in cycles 1-2 with ram_dout 0xDD then 0xCC; mem_done in cycle 3; RAM[0x22] unchanged.
REQ-038 Load: len=1, byte 0x80 at the address -> mem_rdata=0x00000080; with len=3 the access is treated as a 4-byte access.
REQ-039 Reset: rst=0 in cycle 2 of a 4-byte write -> no further ram_wr, no done, state IDLE; with MEM_CTRL_PERF_CNT_EN defined, counters read 0.

Source files
------------

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-wide RAM controller arbitrating instruction fetch and load/store
// Optional perf counters: define MEM_CTRL_PERF_CNT_EN.
module mem_ctrl #(
  parameter int RAM_AW = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [31:0]       mem_addr,
  input  logic [2:0]        mem_len,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [RAM_AW-1:0] ram_a,
  output logic              ram_wr
`ifdef MEM_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_cnt,
  output logic [31:0]       perf_mem_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state, state_nx;
  logic [RAM_AW-1:0] addr_q;
  logic [2:0]        len_q;
  logic [2:0]        cnt_q;
  logic [2:0]        cnt_m1;
  logic [31:0]       wdata_q;
  logic              is_mem_q;
  logic [31:0]       rbuf_q, rbuf_nx;
  logic [31:0]       if_data_q, mem_rdata_q;
  logic [RAM_AW-1:0] byte_addr;
  logic              unused_bits;

  assign unused_bits = ^{if_addr[31:RAM_AW], mem_addr[31:RAM_AW], cnt_m1[2]};
  assign if_data     = if_data_q;
  assign mem_rdata   = mem_rdata_q;
  assign byte_addr   = addr_q + RAM_AW'(cnt_q);

  function automatic logic [2:0] len_dec(input logic [2:0] l);
    case (l)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Outputs are gated by reset so a write in flight never lands on the reset edge.
  always_comb begin
    state_nx = state;
    ram_wr   = 1'b0;
    ram_a    = '0;
    ram_dout = '0;
    if_done  = 1'b0;
    mem_done = 1'b0;
    rbuf_nx  = rbuf_q;
    cnt_m1   = cnt_q - 3'd1;
    if (rst) begin
      case (state)
        IDLE: begin
          if (mem_req)     state_nx = mem_we ? WRITE : READ;
          else if (if_req) state_nx = READ;
        end
        READ: begin
          if (cnt_q < len_q) ram_a = byte_addr;
          if (cnt_q != 3'd0) rbuf_nx[{cnt_m1[1:0], 3'b000} +: 8] = ram_din;
          if (cnt_q == len_q) state_nx = DONE;
        end
        WRITE: begin
          ram_wr   = 1'b1;
          ram_a    = byte_addr;
          ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          if (cnt_q == len_q - 3'd1) state_nx = DONE;
        end
        DONE: begin
          if_done  = ~is_mem_q;
          mem_done = is_mem_q;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      wdata_q     <= '0;
      is_mem_q    <= 1'b0;
      rbuf_q      <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_q  <= '0;
          rbuf_q <= '0;
          if (mem_req) begin
            is_mem_q <= 1'b1;
            addr_q   <= mem_addr[RAM_AW-1:0];
            len_q    <= len_dec(mem_len);
            wdata_q  <= mem_wdata;
          end else if (if_req) begin
            is_mem_q <= 1'b0;
            addr_q   <= if_addr[RAM_AW-1:0];
            len_q    <= 3'd4;
            wdata_q  <= '0;
          end
        end
        READ: begin
          cnt_q  <= cnt_q + 3'd1;
          rbuf_q <= rbuf_nx;
          if (cnt_q == len_q) begin
            if (is_mem_q) mem_rdata_q <= rbuf_nx;
            else          if_data_q   <= rbuf_nx;
          end
        end
        WRITE:   cnt_q <= cnt_q + 3'd1;
        default: ;
      endcase
    end
  end

`ifdef MEM_CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_if_cnt  <= '0;
      perf_mem_cnt <= '0;
    end else begin
      if (if_done)  perf_if_cnt  <= perf_if_cnt + 32'd1;
      if (mem_done) perf_mem_cnt <= perf_mem_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - scoreboard bench for mem_ctrl
module tb_mem_ctrl;
  logic        clk = 0;
  logic        rst;
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [2:0]  mem_len;
  logic        if_done, mem_done, ram_wr;
  logic [31:0] if_data, mem_rdata;
  logic [7:0]  ram_din, ram_dout;
  logic [16:0] ram_a;
`ifdef MEM_CTRL_PERF_CNT_EN
  logic [31:0] perf_if_cnt, perf_mem_cnt;
`endif

  mem_ctrl #(.RAM_AW(17)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
`ifdef MEM_CTRL_PERF_CNT_EN
    , .perf_if_cnt(perf_if_cnt), .perf_mem_cnt(perf_mem_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:(1<<17)-1];
  always @(posedge clk) begin
    ram_din <= ram[ram_a];
    if (ram_wr) ram[ram_a] <= ram_dout;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {bit is_mem; bit chk_data; logic [31:0] data; int cyc;} exp_t;
  typedef struct {int cyc; logic [16:0] a; logic [7:0] d;} wexp_t;
  exp_t  eq[$];
  wexp_t wq[$];
  int total = 0, passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: pop and compare whenever the DUT presents a done pulse or a RAM write.
  always @(negedge clk) begin
    if (if_done || mem_done) begin
      total++;
      if (eq.size() == 0) begin
        $display("FAIL done_unexpected: got if=%0b mem=%0b at cycle %0d expected none", if_done, mem_done, cyc);
      end else begin
        exp_t e;
        logic [31:0] d;
        e = eq.pop_front();
        d = e.is_mem ? mem_rdata : if_data;
        if ((if_done && mem_done) || (mem_done != e.is_mem) || (cyc != e.cyc) || (e.chk_data && d !== e.data))
          $display("FAIL done: got mem=%0b data=%h cycle=%0d expected mem=%0b data=%h cycle=%0d",
                   mem_done, d, cyc, e.is_mem, e.data, e.cyc);
        else passed++;
      end
    end
    if (ram_wr) begin
      total++;
      if (wq.size() == 0) begin
        $display("FAIL write_unexpected: got a=%h d=%h at cycle %0d expected none", ram_a, ram_dout, cyc);
      end else begin
        wexp_t w;
        w = wq.pop_front();
        if (ram_a !== w.a || ram_dout !== w.d || cyc != w.cyc)
          $display("FAIL write: got a=%h d=%h cycle=%0d expected a=%h d=%h cycle=%0d",
                   ram_a, ram_dout, cyc, w.a, w.d, w.cyc);
        else passed++;
      end
    end
  end

  int t0;
  task automatic start();
    @(posedge clk); #1;
    t0 = cyc;
  endtask

  task automatic push_done(input bit is_mem, input bit cd, input logic [31:0] d, input int c);
    exp_t e;
    e.is_mem = is_mem; e.chk_data = cd; e.data = d; e.cyc = c;
    eq.push_back(e);
  endtask

  task automatic push_wr(input int c, input logic [16:0] a, input logic [7:0] d);
    wexp_t w;
    w.cyc = c; w.a = a; w.d = d;
    wq.push_back(w);
  endtask

  task automatic run_until(input bit wif, input bit wmem);
    bit gi, gm, di, dm;
    int n;
    gi = !wif; gm = !wmem; n = 0;
    while (!(gi && gm) && n < 60) begin
      @(negedge clk);
      n++;
      di = if_done; dm = mem_done;
      @(posedge clk); #1;
      if (di) begin if_req = 0; gi = 1; end
      if (dm) begin mem_req = 0; gm = 1; end
    end
    if (!(gi && gm)) begin
      total++;
      $display("FAIL timeout: got if_seen=%0b mem_seen=%0b expected both", gi, gm);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] len);
    start();
    mem_req = 1; mem_we = 0; mem_addr = a; mem_len = len; mem_wdata = 32'h0;
  endtask

  initial begin
    for (int i = 0; i < (1 << 17); i++) ram[i] = 8'h00;
    ram[17'h100] = 8'h13; ram[17'h101] = 8'h05;
    ram[17'h200] = 8'h11; ram[17'h201] = 8'h22; ram[17'h202] = 8'h33; ram[17'h203] = 8'h44;
    ram[17'h022] = 8'h77;
    ram[17'h300] = 8'h80; ram[17'h301] = 8'hFF; ram[17'h302] = 8'h12; ram[17'h303] = 8'h34;
    ram[17'h1FFFF] = 8'hAB; ram[17'h00000] = 8'hCD;
    ram[17'h041] = 8'h5A;
    rst = 0; if_req = 0; mem_req = 0; mem_we = 0;
    if_addr = 0; mem_addr = 0; mem_len = 0; mem_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {28'h0, if_done, mem_done, ram_wr, |ram_a}, 32'h0);
    chk("rst_if_data", if_data, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    @(posedge clk); #1 rst = 1;

    start(); if_req = 1; if_addr = 32'h100;
    push_done(0, 1, 32'h00000513, t0 + 6);
    run_until(1, 0);

    start(); if_req = 1; if_addr = 32'h100;
    mem_req = 1; mem_we = 0; mem_addr = 32'h200; mem_len = 3'd4;
    push_done(1, 1, 32'h44332211, t0 + 6);
    push_done(0, 1, 32'h00000513, t0 + 13);
    run_until(1, 1);

    start(); mem_req = 1; mem_we = 1; mem_addr = 32'h20; mem_len = 3'd2; mem_wdata = 32'hAABBCCDD;
    push_wr(t0 + 1, 17'h020, 8'hDD);
    push_wr(t0 + 2, 17'h021, 8'hCC);
    push_done(1, 0, 32'h0, t0 + 3);
    run_until(0, 1);
    chk("ram_22_kept", {24'h0, ram[17'h022]}, 32'h77);
    chk("ram_20_written", {24'h0, ram[17'h020]}, 32'hDD);
    chk("if_data_held", if_data, 32'h00000513);

    load(32'h300, 3'd1);
    push_done(1, 1, 32'h00000080, t0 + 3);
    run_until(0, 1);

    load(32'h300, 3'd3);
    push_done(1, 1, 32'h3412FF80, t0 + 6);
    run_until(0, 1);

    load(32'h0003FFFF, 3'd2);
    push_done(1, 1, 32'h0000CDAB, t0 + 4);
    run_until(0, 1);

    start(); mem_req = 1; mem_we = 1; mem_addr = 32'h40; mem_len = 3'd4; mem_wdata = 32'h11223344;
    push_wr(t0 + 1, 17'h040, 8'h44);
    @(posedge clk); @(posedge clk); #1 rst = 0;
    @(posedge clk); @(posedge clk); #1;
    mem_req = 0; rst = 1;
    repeat (8) @(posedge clk);
    #1;
    chk("rst_abort_ram41", {24'h0, ram[17'h041]}, 32'h5A);
    chk("rst_abort_if_data", if_data, 32'h0);
    chk("rst_abort_mem_rdata", mem_rdata, 32'h0);
`ifdef MEM_CTRL_PERF_CNT_EN
    chk("perf_if_cnt", perf_if_cnt, 32'h0);
    chk("perf_mem_cnt", perf_mem_cnt, 32'h0);
`endif
    chk("done_queue_empty", eq.size(), 32'h0);
    chk("write_queue_empty", wq.size(), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
